// File: rtl/axi_mem_tester.sv
// AXI4 memory tester. It writes NUM_BURSTS INCR bursts of a seed-derived
// pattern, reads the same region back, and reports the result through
// done, pass, err_count and first_err_addr.
// Only one transaction is outstanding at a time.
module axi_mem_tester #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       BURST_LEN  = 16,
  parameter int unsigned       NUM_BURSTS = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [127:0]      m_axi_wdata,
  output logic [15:0]       m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [127:0]      m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  localparam int unsigned       BW         = $clog2(BURST_LEN + 1);
  localparam int unsigned       NW         = $clog2(NUM_BURSTS + 1);
  localparam logic [BW-1:0]     LAST_BEAT  = BW'(BURST_LEN - 1);
  localparam logic [NW-1:0]     LAST_BURST = NW'(NUM_BURSTS - 1);
  localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN * 16);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  state_t            state;
  logic [31:0]       seed_q;
  logic [31:0]       g_base;      // global index of beat 0 of the current burst
  logic [BW-1:0]     beat;
  logic [NW-1:0]     burst;
  logic [ADDR_W-1:0] burst_addr;

  logic [31:0]       beat_word;
  logic [ADDR_W-1:0] beat_addr;
  logic              rd_bad;
  logic              err_hit;
  logic [ADDR_W-1:0] err_at;

  assign m_axi_awaddr  = burst_addr;
  assign m_axi_araddr  = burst_addr;
  assign m_axi_awlen   = 8'(BURST_LEN - 1);
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_awsize  = 3'b100;
  assign m_axi_arsize  = 3'b100;
  assign m_axi_awburst = 2'b01;
  assign m_axi_arburst = 2'b01;
  assign m_axi_wstrb   = '1;

  // Expected pattern word, beat address and per-cycle error detection
  always_comb begin
    beat_word = seed_q + g_base + 32'(beat);
    beat_addr = burst_addr + (ADDR_W'(beat) << 4);
    rd_bad    = (m_axi_rdata != {4{beat_word}}) || (m_axi_rresp != 2'b00) ||
                (m_axi_rlast != (beat == LAST_BEAT));
    err_hit   = 1'b0;
    err_at    = burst_addr;
    if (state == S_B && m_axi_bready && m_axi_bvalid && m_axi_bresp != 2'b00) begin
      err_hit = 1'b1;
    end
    if (state == S_R && m_axi_rready && m_axi_rvalid && rd_bad) begin
      err_hit = 1'b1;
      err_at  = beat_addr;
    end
  end

  // Main sequencer: write phase, read-back phase, result registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= S_IDLE;
      seed_q         <= '0;
      g_base         <= '0;
      beat           <= '0;
      burst          <= '0;
      burst_addr     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      m_axi_awvalid  <= 1'b0;
      m_axi_wvalid   <= 1'b0;
      m_axi_wdata    <= '0;
      m_axi_wlast    <= 1'b0;
      m_axi_bready   <= 1'b0;
      m_axi_arvalid  <= 1'b0;
      m_axi_rready   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            seed_q         <= seed;
            g_base         <= '0;
            beat           <= '0;
            burst          <= '0;
            burst_addr     <= BASE_ADDR;
            err_count      <= '0;
            first_err_addr <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            m_axi_awvalid  <= 1'b1;
            state          <= S_AW;
          end
        end
        S_AW: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b1;
            m_axi_wdata   <= {4{beat_word}};
            m_axi_wlast   <= (LAST_BEAT == '0);
            state         <= S_W;
          end
        end
        S_W: begin
          if (m_axi_wready) begin
            if (beat == LAST_BEAT) begin
              m_axi_wvalid <= 1'b0;
              m_axi_wlast  <= 1'b0;
              m_axi_bready <= 1'b1;
              beat         <= '0;
              state        <= S_B;
            end else begin
              beat        <= beat + BW'(1);
              m_axi_wdata <= {4{beat_word + 32'd1}};
              m_axi_wlast <= (beat + BW'(1) == LAST_BEAT);
            end
          end
        end
        S_B: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (burst == LAST_BURST) begin
              burst         <= '0;
              g_base        <= '0;
              burst_addr    <= BASE_ADDR;
              m_axi_arvalid <= 1'b1;
              state         <= S_AR;
            end else begin
              burst         <= burst + NW'(1);
              g_base        <= g_base + 32'(BURST_LEN);
              burst_addr    <= burst_addr + BURST_STEP;
              m_axi_awvalid <= 1'b1;
              state         <= S_AW;
            end
          end
        end
        S_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            beat          <= '0;
            state         <= S_R;
          end
        end
        S_R: begin
          if (m_axi_rvalid) begin
            // An early rlast ends the burst; g_base keeps the next burst's pattern aligned.
            if (m_axi_rlast || beat == LAST_BEAT) begin
              m_axi_rready <= 1'b0;
              beat         <= '0;
              if (burst == LAST_BURST) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (err_count == '0) && !err_hit;
                state <= S_DONE;
              end else begin
                burst         <= burst + NW'(1);
                g_base        <= g_base + 32'(BURST_LEN);
                burst_addr    <= burst_addr + BURST_STEP;
                m_axi_arvalid <= 1'b1;
                state         <= S_AR;
              end
            end else begin
              beat <= beat + BW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      if (err_hit) begin
        if (err_count == '0) first_err_addr <= err_at;
        if (err_count != '1) err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_tester.sv
// Bench for axi_mem_tester. It provides a memory slave with configurable stalls
// and fault injection, a protocol and pattern monitor, table-driven runs,
// and hand-written reset, busy-start and seed-wrap sequences.
module tb_axi_mem_tester;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic         start;
  logic [31:0]  seed;
  logic         busy, done, pass;
  logic [15:0]  err_count;
  logic [31:0]  first_err_addr;
  logic [31:0]  m_axi_awaddr, m_axi_araddr;
  logic [7:0]   m_axi_awlen, m_axi_arlen;
  logic [2:0]   m_axi_awsize, m_axi_arsize;
  logic [1:0]   m_axi_awburst, m_axi_arburst;
  logic         m_axi_awvalid, m_axi_awready;
  logic [127:0] m_axi_wdata;
  logic [15:0]  m_axi_wstrb;
  logic         m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]   m_axi_bresp;
  logic         m_axi_bvalid, m_axi_bready;
  logic         m_axi_arvalid, m_axi_arready;
  logic [127:0] m_axi_rdata;
  logic [1:0]   m_axi_rresp;
  logic         m_axi_rlast, m_axi_rvalid, m_axi_rready;

  always #5 aclk = ~aclk;

  axi_mem_tester #(
    .ADDR_W(32), .BURST_LEN(16), .NUM_BURSTS(4), .BASE_ADDR(32'h0000_0000)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // Slave knobs
  bit          stall_en, corrupt_en, rresp_en;
  logic [31:0] corrupt_addr, rresp_addr;
  int          bresp_burst;

  // Slave memory model (64 x 128-bit beats covering 0x000..0x3FF)
  logic [127:0] mem [0:63];
  logic [31:0]  wr_addr, rd_addr, rd_cur;
  int unsigned  wr_beat, rd_beat;
  logic         rd_active, r_hold;
  logic         rnd_aw, rnd_w, rnd_ar, rnd_r;

  assign m_axi_awready = !stall_en || rnd_aw;
  assign m_axi_wready  = !stall_en || rnd_w;
  assign m_axi_arready = !stall_en || rnd_ar;
  assign rd_cur        = rd_addr + 32'(rd_beat * 16);
  assign m_axi_rvalid  = rd_active && (!stall_en || rnd_r || r_hold);
  assign m_axi_rdata   = mem[rd_cur[9:4]] ^ ((corrupt_en && rd_cur == corrupt_addr) ? 128'h1 : 128'h0);
  assign m_axi_rresp   = (rresp_en && rd_cur == rresp_addr) ? 2'b10 : 2'b00;
  assign m_axi_rlast   = (rd_beat == 15);

  // Slave: accepts bursts, stores writes, answers reads with injected faults
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_active <= 1'b0; r_hold <= 1'b0; m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
      wr_beat <= 0; rd_beat <= 0; wr_addr <= '0; rd_addr <= '0;
      rnd_aw <= 1'b0; rnd_w <= 1'b0; rnd_ar <= 1'b0; rnd_r <= 1'b0;
    end else begin
      rnd_aw <= 1'($urandom); rnd_w <= 1'($urandom);
      rnd_ar <= 1'($urandom); rnd_r <= 1'($urandom);
      if (m_axi_awvalid && m_axi_awready) begin
        wr_addr <= m_axi_awaddr;
        wr_beat <= 0;
      end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (m_axi_wvalid && m_axi_wready) begin
        mem[6'(wr_addr[9:4] + 6'(wr_beat))] <= m_axi_wdata;
        wr_beat <= wr_beat + 1;
        if (m_axi_wlast) begin
          m_axi_bvalid <= 1'b1;
          m_axi_bresp  <= (bresp_burst == int'(wr_addr >> 8)) ? 2'b10 : 2'b00;
        end
      end
      if (m_axi_arvalid && m_axi_arready) begin
        rd_addr   <= m_axi_araddr;
        rd_beat   <= 0;
        rd_active <= 1'b1;
      end
      if (m_axi_rvalid && m_axi_rready) begin
        rd_beat <= rd_beat + 1;
        r_hold  <= 1'b0;
        if (rd_beat == 15) rd_active <= 1'b0;
      end else begin
        r_hold <= m_axi_rvalid;
      end
    end
  end

  // Monitor state
  int unsigned  viol, w_beats, r_beats, aw_cnt, ar_cnt;
  logic [31:0]  mon_seed, prev_awaddr, prev_araddr;
  logic [127:0] prev_wdata;
  logic         prev_wlast, hold_aw, hold_w, hold_ar, mon_bad;
  logic [127:0] wlog [0:63];

  // Protocol and pattern checks, one flag per cycle
  always_comb begin
    mon_bad = 1'b0;
    if (m_axi_awvalid && m_axi_wvalid) mon_bad = 1'b1;
    if (hold_aw && (!m_axi_awvalid || m_axi_awaddr != prev_awaddr)) mon_bad = 1'b1;
    if (hold_ar && (!m_axi_arvalid || m_axi_araddr != prev_araddr)) mon_bad = 1'b1;
    if (hold_w && (!m_axi_wvalid || m_axi_wdata != prev_wdata || m_axi_wlast != prev_wlast))
      mon_bad = 1'b1;
    if (m_axi_awvalid && m_axi_awready &&
        (m_axi_awaddr != 32'(aw_cnt * 256) || m_axi_awlen != 8'd15 ||
         m_axi_awsize != 3'b100 || m_axi_awburst != 2'b01)) mon_bad = 1'b1;
    if (m_axi_arvalid && m_axi_arready &&
        (m_axi_araddr != 32'(ar_cnt * 256) || m_axi_arlen != 8'd15 ||
         m_axi_arsize != 3'b100 || m_axi_arburst != 2'b01)) mon_bad = 1'b1;
    if (m_axi_wvalid && m_axi_wready &&
        (m_axi_wdata != {4{mon_seed + 32'(w_beats)}} || m_axi_wlast != ((w_beats % 16) == 15) ||
         m_axi_wstrb != 16'hFFFF)) mon_bad = 1'b1;
  end

  // Monitor bookkeeping; counters restart on each accepted start
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hold_aw <= 1'b0; hold_w <= 1'b0; hold_ar <= 1'b0;
      viol <= 0; w_beats <= 0; r_beats <= 0; aw_cnt <= 0; ar_cnt <= 0; mon_seed <= '0;
    end else begin
      hold_aw     <= m_axi_awvalid && !m_axi_awready;
      hold_w      <= m_axi_wvalid && !m_axi_wready;
      hold_ar     <= m_axi_arvalid && !m_axi_arready;
      prev_awaddr <= m_axi_awaddr;
      prev_araddr <= m_axi_araddr;
      prev_wdata  <= m_axi_wdata;
      prev_wlast  <= m_axi_wlast;
      if (start && !busy) begin
        viol <= 0; w_beats <= 0; r_beats <= 0; aw_cnt <= 0; ar_cnt <= 0; mon_seed <= seed;
      end else begin
        if (mon_bad) viol <= viol + 1;
        if (m_axi_awvalid && m_axi_awready) aw_cnt <= aw_cnt + 1;
        if (m_axi_arvalid && m_axi_arready) ar_cnt <= ar_cnt + 1;
        if (m_axi_rvalid && m_axi_rready) r_beats <= r_beats + 1;
        if (m_axi_wvalid && m_axi_wready) begin
          wlog[6'(w_beats)] <= m_axi_wdata;
          w_beats <= w_beats + 1;
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [31:0] s);
    seed  = s;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge aclk);
      if (done) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_wbeats(input int unsigned target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge aclk);
      if (w_beats == target) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic clear_knobs();
    stall_en = 0; corrupt_en = 0; rresp_en = 0;
    corrupt_addr = '0; rresp_addr = '0; bresp_burst = -1;
  endtask

  typedef struct {
    logic [31:0] seed;
    bit          stall;
    bit          corrupt;
    logic [31:0] corrupt_addr;
    int          bresp_burst;
    bit          rresp;
    logic [31:0] rresp_addr;
    logic [15:0] exp_err;
    logic [31:0] exp_first;
    bit          exp_pass;
    logic [31:0] exp_w0;
    logic [31:0] exp_w63;
  } vec_t;

  vec_t vecs [7];

  initial begin
    bit ok;

    vecs[0] = '{32'h0000_1000, 0, 0, 32'h0,   -1, 0, 32'h0,   16'd0, 32'h000, 1, 32'h0000_1000, 32'h0000_103F};
    vecs[1] = '{32'h2222_0000, 1, 0, 32'h0,   -1, 0, 32'h0,   16'd0, 32'h000, 1, 32'h2222_0000, 32'h2222_003F};
    vecs[2] = '{32'h0000_1000, 0, 1, 32'h130, -1, 0, 32'h0,   16'd1, 32'h130, 0, 32'h0000_1000, 32'h0000_103F};
    vecs[3] = '{32'h0000_1000, 0, 0, 32'h0,    2, 0, 32'h0,   16'd1, 32'h200, 0, 32'h0000_1000, 32'h0000_103F};
    vecs[4] = '{32'h0000_1000, 0, 0, 32'h0,    2, 1, 32'h50,  16'd2, 32'h200, 0, 32'h0000_1000, 32'h0000_103F};
    vecs[5] = '{32'hABCD_0000, 1, 0, 32'h0,   -1, 1, 32'h3F0, 16'd1, 32'h3F0, 0, 32'hABCD_0000, 32'hABCD_003F};
    vecs[6] = '{32'h0000_0000, 1, 1, 32'h000,  3, 0, 32'h0,   16'd2, 32'h300, 0, 32'h0000_0000, 32'h0000_003F};

    clear_knobs();
    aresetn = 1'b0;
    start   = 1'b0;
    seed    = '0;
    repeat (4) @(negedge aclk);
    check("reset ctrl", {busy, done, pass, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                         m_axi_arvalid, m_axi_rready}, 8'h00);
    check("reset err_count", err_count, 16'd0);
    check("reset first_err_addr", first_err_addr, 32'h0);
    aresetn = 1'b1;
    @(negedge aclk);

    // Table-driven full runs
    for (int i = 0; i < 7; i++) begin
      stall_en     = vecs[i].stall;
      corrupt_en   = vecs[i].corrupt;
      corrupt_addr = vecs[i].corrupt_addr;
      bresp_burst  = vecs[i].bresp_burst;
      rresp_en     = vecs[i].rresp;
      rresp_addr   = vecs[i].rresp_addr;
      pulse_start(vecs[i].seed);
      wait_done(ok);
      check($sformatf("row%0d done", i), ok, 1'b1);
      check($sformatf("row%0d busy", i), busy, 1'b0);
      check($sformatf("row%0d pass", i), pass, vecs[i].exp_pass);
      check($sformatf("row%0d err_count", i), err_count, vecs[i].exp_err);
      check($sformatf("row%0d first_err_addr", i), first_err_addr, vecs[i].exp_first);
      check($sformatf("row%0d protocol", i), viol, 0);
      check($sformatf("row%0d w_beats", i), w_beats, 64);
      check($sformatf("row%0d r_beats", i), r_beats, 64);
      check($sformatf("row%0d wdata0", i), wlog[0], {4{vecs[i].exp_w0}});
      check($sformatf("row%0d wdata63", i), wlog[63], {4{vecs[i].exp_w63}});
    end

    // Reset asserted mid-write (burst 1, beat 5) after a write error was logged
    clear_knobs();
    bresp_burst = 0;
    pulse_start(32'h0000_1000);
    wait_wbeats(21, ok);
    check("midrun reached", ok, 1'b1);
    check("midrun pre-reset err", err_count, 16'd1);
    check("midrun pre-reset wvalid", m_axi_wvalid, 1'b1);
    aresetn = 1'b0;
    #1;
    check("async reset ctrl", {busy, done, pass, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                               m_axi_arvalid, m_axi_rready}, 8'h00);
    check("async reset err_count", err_count, 16'd0);
    check("async reset first_err_addr", first_err_addr, 32'h0);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    bresp_burst = -1;
    @(negedge aclk);
    pulse_start(32'h0000_1000);
    wait_done(ok);
    check("post-reset done", ok, 1'b1);
    check("post-reset pass", pass, 1'b1);
    check("post-reset err_count", err_count, 16'd0);
    check("post-reset protocol", viol, 0);

    // start while busy must be ignored
    pulse_start(32'h0000_1000);
    wait_wbeats(10, ok);
    check("busy-start reached", ok, 1'b1);
    pulse_start(32'h5555_0000);
    check("busy-start still busy", busy, 1'b1);
    wait_done(ok);
    check("busy-start done", ok, 1'b1);
    check("busy-start pass", pass, 1'b1);
    check("busy-start protocol", viol, 0);
    check("busy-start w_beats", w_beats, 64);
    check("busy-start wdata63", wlog[63], {4{32'h0000_103F}});

    // Restart from DONE with a seed that wraps at g=16
    stall_en = 1;
    pulse_start(32'hFFFF_FFF0);
    wait_done(ok);
    check("wrap done", ok, 1'b1);
    check("wrap pass", pass, 1'b1);
    check("wrap err_count", err_count, 16'd0);
    check("wrap protocol", viol, 0);
    check("wrap wdata0", wlog[0], {4{32'hFFFF_FFF0}});
    check("wrap wdata15", wlog[15], {4{32'hFFFF_FFFF}});
    check("wrap wdata16", wlog[16], {4{32'h0000_0000}});
    check("wrap wdata63", wlog[63], {4{32'h0000_002F}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
